// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - state encoding and op_class constants for step_sequencer
package seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WAIT   = 3'd5,
        S_WB     = 3'd6,
        S_HALTED = 3'd7
    } state_t;

    localparam logic [2:0] OP_ALU   = 3'd0;
    localparam logic [2:0] OP_LOAD  = 3'd1;
    localparam logic [2:0] OP_STORE = 3'd2;
    localparam logic [2:0] OP_MULTI = 3'd3;
    localparam logic [2:0] OP_HALT  = 3'd4;
    localparam logic [2:0] OP_NOP   = 3'd5;

endpackage

// File: rtl/step_sequencer_step_counter.sv
// rtl/step_sequencer_step_counter.sv - saturating per-state cycle counter
module step_counter #(
    parameter int STEP_BITS = 6
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 restart,
    output logic [STEP_BITS-1:0] count
);

    localparam logic [STEP_BITS-1:0] ONE = {{(STEP_BITS-1){1'b0}}, 1'b1};

    // Restart on a state change, otherwise count up and hold at all-ones
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            count <= '0;
        end else if (restart) begin
            count <= '0;
        end else if (count != '1) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/step_sequencer.sv
// rtl/step_sequencer.sv - multi-cycle instruction sequencer with unit handshakes, halt and watchdog
module step_sequencer
    import seq_pkg::*;
#(
    parameter int STEP_BITS = 6,
    parameter int NUM_UNITS = 2,
    parameter int UNIT_BITS = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic [2:0]           op_class,
    input  logic [UNIT_BITS-1:0] unit_sel,
    input  logic                 mem_ack,
    input  logic [NUM_UNITS-1:0] unit_done,
    input  logic                 halt,
    input  logic                 resume,
    output logic                 fetch_req,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic                 ir_en,
    output logic                 exec_en,
    output logic                 ma_en,
    output logic                 wb_en,
    output logic [NUM_UNITS-1:0] unit_start,
    output logic                 halted,
    output logic                 err,
    output logic [STEP_BITS-1:0] step
);

    localparam logic [UNIT_BITS:0] UNIT_COUNT = (UNIT_BITS+1)'(NUM_UNITS);

    state_t                 state;
    state_t                 state_next;
    state_t                 boundary;
    logic                   halt_pending;
    logic                   err_reg;
    logic                   sel_valid;
    logic                   sel_done;
    logic [NUM_UNITS-1:0]   sel_onehot;
    logic                   wd_fire;
    logic                   bad_sel;

    assign sel_valid = ({1'b0, unit_sel} < UNIT_COUNT);
    assign boundary  = (halt || halt_pending) ? S_HALTED : S_FETCH;

    // Decode unit_sel into a one-hot mask and pick out the selected done bit
    always_comb begin
        sel_onehot = '0;
        sel_done   = 1'b0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (unit_sel == UNIT_BITS'(i)) begin
                sel_onehot[i] = 1'b1;
                sel_done      = unit_done[i];
            end
        end
    end

    // Next-state selection; instruction boundaries resolve to HALTED or FETCH
    always_comb begin
        state_next = state;
        wd_fire    = 1'b0;
        bad_sel    = 1'b0;
        case (state)
            S_IDLE:   state_next = S_FETCH;
            S_FETCH:  if (mem_ack) state_next = S_DECODE;
            S_DECODE: state_next = S_EXEC;
            S_EXEC: begin
                case (op_class)
                    OP_ALU:   state_next = boundary;
                    OP_LOAD,
                    OP_STORE: state_next = S_MEM;
                    OP_MULTI: begin
                        if (sel_valid) begin
                            state_next = S_WAIT;
                        end else begin
                            state_next = boundary;
                            bad_sel    = 1'b1;
                        end
                    end
                    OP_HALT:  state_next = S_HALTED;
                    default:  state_next = boundary;
                endcase
            end
            S_MEM: begin
                if (mem_ack) begin
                    state_next = (op_class == OP_STORE) ? boundary : S_WB;
                end
            end
            S_WAIT: begin
                if (sel_done) begin
                    state_next = S_WB;
                end else if (step == '1) begin
                    state_next = boundary;
                    wd_fire    = 1'b1;
                end
            end
            S_WB:     state_next = boundary;
            S_HALTED: if (resume) state_next = S_FETCH;
            default:  state_next = S_IDLE;
        endcase
    end

    // State, sticky error and deferred-halt registers
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state        <= S_IDLE;
            err_reg      <= 1'b0;
            halt_pending <= 1'b0;
        end else begin
            state <= state_next;

            if (wd_fire || bad_sel) begin
                err_reg <= 1'b1;
            end else if (state == S_HALTED && resume) begin
                err_reg <= 1'b0;
            end

            // A halt seen together with resume still applies to the next instruction
            if (state != S_HALTED && state_next == S_HALTED) begin
                halt_pending <= 1'b0;
            end else if (halt && (state != S_HALTED || resume)) begin
                halt_pending <= 1'b1;
            end
        end
    end

    step_counter #(
        .STEP_BITS (STEP_BITS)
    ) u_step_counter (
        .clk     (clk),
        .clr     (clr),
        .restart (state_next != state),
        .count   (step)
    );

    // Datapath enables from the current state; EXEC also looks at op_class
    always_comb begin
        fetch_req  = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        ir_en      = 1'b0;
        exec_en    = 1'b0;
        ma_en      = 1'b0;
        wb_en      = 1'b0;
        unit_start = '0;
        halted     = 1'b0;
        case (state)
            S_FETCH: begin
                fetch_req = 1'b1;
                mem_req   = 1'b1;
            end
            S_DECODE: ir_en = 1'b1;
            S_EXEC: begin
                exec_en = 1'b1;
                case (op_class)
                    OP_ALU:   wb_en = 1'b1;
                    OP_LOAD,
                    OP_STORE: ma_en = 1'b1;
                    OP_MULTI: unit_start = sel_onehot;
                    default:  ;
                endcase
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = (op_class == OP_STORE);
            end
            S_WB:     wb_en  = 1'b1;
            S_HALTED: halted = 1'b1;
            default:  ;
        endcase
    end

    assign err = err_reg;

endmodule
